dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/misc_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 57 +++++
 rtl/rr_arb2.sv | 25 ++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/misc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : misc_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package misc_pkg;

    localparam int c_data_w_def = 16;
    localparam int c_addr_w_def = 16;

    // Size of the attached data memory in bytes; higher address bits must be 0.
    localparam int c_mem_bytes = 512;
    localparam int c_mem_aw    = $clog2(c_mem_bytes);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Request/response signals of both ports plus the memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
    import misc_pkg::*;
#(
    parameter int DATA_W = c_data_w_def,
    parameter int ADDR_W = c_addr_w_def
);
    logic              p0_valid;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ready;
    logic              p0_done;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic              p1_valid;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ready;
    logic              p1_done;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic [ADDR_W-1:0] mem_access_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    // Arbiter side
    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata,
        input  p1_valid, p1_we, p1_addr, p1_wdata,
        input  mem_read_data,
        output p0_ready, p0_done, p0_rdata, p0_err,
        output p1_ready, p1_done, p1_rdata, p1_err,
        output mem_access_addr, mem_write_data, mem_write_en, mem_read
    );

    // Requesters and memory side
    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata,
        output p1_valid, p1_we, p1_addr, p1_wdata,
        output mem_read_data,
        input  p0_ready, p0_done, p0_rdata, p0_err,
        input  p1_ready, p1_done, p1_rdata, p1_err,
        input  mem_access_addr, mem_write_data, mem_write_en, mem_read
    );
endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way combinational grant selection, round-robin or fixed.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] grant
);

    // On a tie the port that did not win last goes first; fixed mode favours port 0.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (rr_en && !last) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter in front of a 512-byte data memory; one
//               access per two cycles, done pulse two cycles after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import misc_pkg::*;
#(
    parameter bit RR_EN  = 1'b1,
    parameter int DATA_W = c_data_w_def,
    parameter int ADDR_W = c_addr_w_def
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last;
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_done0;
    logic              r_done1;
    logic              r_err0;
    logic              r_err1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_in_range;

    rr_arb2 u_rr_arb2 (
        .req   ({bus.p1_valid, bus.p0_valid}),
        .last  (r_last),
        .rr_en (RR_EN),
        .grant (w_grant)
    );

    // Ready is gated by rst_n so no handshake completes while reset is held.
    assign w_accept   = (r_state == IDLE) && rst_n && (w_grant != 2'b00);
    assign w_in_range = (r_addr[ADDR_W-1:c_mem_aw] == '0);

    // Next-state decode, handshake and memory-side outputs.
    always_comb begin
        w_state_nxt         = r_state;
        bus.p0_ready        = 1'b0;
        bus.p1_ready        = 1'b0;
        bus.mem_access_addr = '0;
        bus.mem_write_data  = '0;
        bus.mem_write_en    = 1'b0;
        bus.mem_read        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    bus.p0_ready = w_grant[0];
                    bus.p1_ready = w_grant[1];
                    w_state_nxt  = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_access_addr = r_addr;
                bus.mem_write_data  = r_wdata;
                bus.mem_write_en    = r_we && w_in_range;
                bus.mem_read        = !r_we && w_in_range;
                w_state_nxt         = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; async reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winner's payload and remember who won for the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_last  <= w_grant[1];
            r_port  <= w_grant[1];
            r_we    <= w_grant[1] ? bus.p1_we    : bus.p0_we;
            r_addr  <= w_grant[1] ? bus.p1_addr  : bus.p0_addr;
            r_wdata <= w_grant[1] ? bus.p1_wdata : bus.p0_wdata;
        end
    end

    // Completion: one-cycle done/err pulse; read data held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            if (r_state == ACCESS) begin
                if (!r_port) begin
                    r_done0 <= 1'b1;
                    r_err0  <= !w_in_range;
                    if (!r_we && w_in_range) begin
                        r_rdata0 <= bus.mem_read_data;
                    end
                end else begin
                    r_done1 <= 1'b1;
                    r_err1  <= !w_in_range;
                    if (!r_we && w_in_range) begin
                        r_rdata1 <= bus.mem_read_data;
                    end
                end
            end
        end
    end

    assign bus.p0_done  = r_done0;
    assign bus.p1_done  = r_done1;
    assign bus.p0_err   = r_err0;
    assign bus.p1_err   = r_err1;
    assign bus.p0_rdata = r_rdata0;
    assign bus.p1_rdata = r_rdata1;

endmodule
`default_nettype wire
